// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters gate decode issue.
// Optional SB_BYPASS_EN lets a same-cycle writeback clear a source hazard combinationally.
module reg_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int ZERO_REG     = 1
) (
    input  logic                                CLK,
    input  logic                                RESET_N,
    input  logic                                ISSUE_V,
    input  logic [$clog2(NUM_REGS)-1:0]         ISSUE_RS1,
    input  logic [$clog2(NUM_REGS)-1:0]         ISSUE_RS2,
    input  logic                                ISSUE_USE_RS1,
    input  logic                                ISSUE_USE_RS2,
    input  logic [$clog2(NUM_REGS)-1:0]         ISSUE_RD,
    input  logic                                ISSUE_WEN,
    output logic                                ISSUE_READY,
    input  logic                                WB_V,
    input  logic [$clog2(NUM_REGS)-1:0]         WB_RD,
    input  logic                                FLUSH,
    output logic [NUM_REGS-1:0]                 BUSY_VEC,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   INFLIGHT,
    output logic                                ERR_UNDERFLOW,
    output logic                                ERR_OVERFLOW
);

    localparam int RW    = $clog2(NUM_REGS);
    localparam int IW    = $clog2(MAX_INFLIGHT + 1);
    localparam int NSLOT = 1 << RW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Slots at or above NUM_REGS are never incremented, so they always read as idle.
    logic [CNT_W-1:0] pending [NSLOT];

    function automatic logic tracked(input logic [RW-1:0] idx);
        logic in_range;
        in_range = 1'b1;
        for (int unsigned r = NUM_REGS; r < NSLOT; r++)
            if (idx == RW'(r)) in_range = 1'b0;
        return in_range && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    logic src1_busy, src2_busy, bypass1, bypass2;
    logic track_rd, rd_ok, fire, inc, wb_trk, wb_dec, wb_uf, ovf;

    always_comb begin
        bypass1 = 1'b0;
        bypass2 = 1'b0;
`ifdef SB_BYPASS_EN
        bypass1 = WB_V && (WB_RD == ISSUE_RS1) && (pending[ISSUE_RS1] == CNT_W'(1));
        bypass2 = WB_V && (WB_RD == ISSUE_RS2) && (pending[ISSUE_RS2] == CNT_W'(1));
`endif
        src1_busy = ISSUE_USE_RS1 && tracked(ISSUE_RS1) && (pending[ISSUE_RS1] != '0) && !bypass1;
        src2_busy = ISSUE_USE_RS2 && tracked(ISSUE_RS2) && (pending[ISSUE_RS2] != '0) && !bypass2;
        track_rd  = ISSUE_WEN && tracked(ISSUE_RD);
        rd_ok     = !track_rd || ((pending[ISSUE_RD] != CNT_MAX) && (INFLIGHT < IW'(MAX_INFLIGHT)));
        ISSUE_READY = RESET_N && !FLUSH && !src1_busy && !src2_busy && rd_ok;

        fire   = ISSUE_V && ISSUE_READY;
        inc    = fire && track_rd;
        wb_trk = WB_V && tracked(WB_RD);
        wb_dec = wb_trk && (pending[WB_RD] != '0);
        wb_uf  = wb_trk && (pending[WB_RD] == '0);
        ovf    = inc && ((pending[ISSUE_RD] == CNT_MAX) || (INFLIGHT >= IW'(MAX_INFLIGHT)));
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned r = 0; r < NSLOT; r++) pending[r] <= '0;
            INFLIGHT <= '0;
        end else if (FLUSH) begin
            for (int unsigned r = 0; r < NSLOT; r++) pending[r] <= '0;
            INFLIGHT <= '0;
        end else begin
            // A fire and a retire on the same register cancel out.
            for (int unsigned r = 0; r < NSLOT; r++) begin
                if (inc && ISSUE_RD == RW'(r) && !(wb_dec && WB_RD == RW'(r)))
                    pending[r] <= pending[r] + 1'b1;
                else if (wb_dec && WB_RD == RW'(r) && !(inc && ISSUE_RD == RW'(r)))
                    pending[r] <= pending[r] - 1'b1;
            end
            unique case ({inc, wb_dec})
                2'b10:   INFLIGHT <= INFLIGHT + 1'b1;
                2'b01:   INFLIGHT <= INFLIGHT - 1'b1;
                default: INFLIGHT <= INFLIGHT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ERR_UNDERFLOW <= 1'b0;
            ERR_OVERFLOW  <= 1'b0;
        end else begin
            if (wb_uf) ERR_UNDERFLOW <= 1'b1;
            if (ovf)   ERR_OVERFLOW  <= 1'b1;
        end
    end

    always_comb begin
        BUSY_VEC = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) BUSY_VEC[r] = (pending[r] != '0);
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus a short random run,
// with expected post-edge state queued by a behavioural model and compared after each edge.
module tb_reg_scoreboard;

    localparam int RW = 5;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          ISSUE_V, ISSUE_USE_RS1, ISSUE_USE_RS2, ISSUE_WEN, ISSUE_READY;
    logic [RW-1:0] ISSUE_RS1, ISSUE_RS2, ISSUE_RD, WB_RD;
    logic          WB_V, FLUSH;
    logic [31:0]   BUSY_VEC;
    logic [2:0]    INFLIGHT;
    logic          ERR_UNDERFLOW, ERR_OVERFLOW;

    reg_scoreboard #(.NUM_REGS(32), .CNT_W(2), .MAX_INFLIGHT(4), .ZERO_REG(1)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .ISSUE_V(ISSUE_V), .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2),
        .ISSUE_USE_RS1(ISSUE_USE_RS1), .ISSUE_USE_RS2(ISSUE_USE_RS2),
        .ISSUE_RD(ISSUE_RD), .ISSUE_WEN(ISSUE_WEN), .ISSUE_READY(ISSUE_READY),
        .WB_V(WB_V), .WB_RD(WB_RD), .FLUSH(FLUSH),
        .BUSY_VEC(BUSY_VEC), .INFLIGHT(INFLIGHT),
        .ERR_UNDERFLOW(ERR_UNDERFLOW), .ERR_OVERFLOW(ERR_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    int m_pend [32];
    int m_infl;
    bit m_uf;

    typedef struct {
        logic [31:0] busy;
        int          infl;
        bit          uf;
        string       tag;
    } exp_t;
    exp_t sbq[$];

    function automatic void m_reset();
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
        m_infl = 0;
        m_uf   = 0;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int r = 0; r < 32; r++) b[r] = (m_pend[r] != 0);
        return b;
    endfunction

    function automatic bit m_src_busy(input bit use_it, input int rs);
        bit b = use_it && rs != 0 && m_pend[rs] != 0;
`ifdef SB_BYPASS_EN
        if (WB_V && int'(WB_RD) == rs && m_pend[rs] == 1) b = 0;
`endif
        return b;
    endfunction

    function automatic bit m_ready();
        bit trk = ISSUE_WEN && ISSUE_RD != 0;
        bit ok  = !trk || (m_pend[ISSUE_RD] < 3 && m_infl < 4);
        return RESET_N && !FLUSH && !m_src_busy(ISSUE_USE_RS1, int'(ISSUE_RS1))
               && !m_src_busy(ISSUE_USE_RS2, int'(ISSUE_RS2)) && ok;
    endfunction

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wen, input bit wbv, input int wbrd, input bit fl);
        ISSUE_V = v; ISSUE_RS1 = RW'(rs1); ISSUE_USE_RS1 = u1;
        ISSUE_RS2 = RW'(rs2); ISSUE_USE_RS2 = u2;
        ISSUE_RD = RW'(rd); ISSUE_WEN = wen;
        WB_V = wbv; WB_RD = RW'(wbrd); FLUSH = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Inputs already driven; checks READY, advances the model, then checks registered state.
    task automatic step(input string tag);
        bit   rdy, fire, dec;
        exp_t e;
        #1;
        rdy = m_ready();
        check({tag, "/ready"}, ISSUE_READY, rdy);
        if (WB_V && WB_RD != 0 && m_pend[WB_RD] == 0) m_uf = 1;
        if (FLUSH) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 0;
            m_infl = 0;
        end else begin
            fire = ISSUE_V && rdy && ISSUE_WEN && ISSUE_RD != 0;
            dec  = WB_V && WB_RD != 0 && m_pend[WB_RD] > 0;
            if (dec)  begin m_pend[WB_RD]--; m_infl--; end
            if (fire) begin m_pend[ISSUE_RD]++; m_infl++; end
        end
        e.busy = m_busy(); e.infl = m_infl; e.uf = m_uf; e.tag = tag;
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        e = sbq.pop_front();
        check({e.tag, "/busy"}, BUSY_VEC, e.busy);
        check({e.tag, "/inflight"}, 32'(INFLIGHT), 32'(e.infl));
        check({e.tag, "/err_uf"}, 32'(ERR_UNDERFLOW), 32'(e.uf));
        check({e.tag, "/err_ov"}, 32'(ERR_OVERFLOW), 32'd0);
    endtask

    task automatic fire_rd(input int rd);
        drive(1, 0, 0, 0, 0, rd, 1, 0, 0, 0); step("fire");
    endtask

    task automatic wb(input int rd);
        drive(0, 0, 0, 0, 0, 0, 0, 1, rd, 0); step("wb");
    endtask

    initial begin
        m_reset();
        idle();
        RESET_N = 1'b0;
        ISSUE_V = 1'b1;
        #2;
        check("rst_ready", ISSUE_READY, 1'b0);
        check("rst_inflight", 32'(INFLIGHT), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        idle();
        @(posedge CLK); #1;

        // Build up state, then assert reset mid-cycle
        wb(12);
        fire_rd(1); fire_rd(2); fire_rd(3);
        check("pre_rst_inflight", 32'(INFLIGHT), 32'd3);
        #2;
        RESET_N = 1'b0;
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("async_inflight", 32'(INFLIGHT), 32'd0);
        check("async_busy", BUSY_VEC, 32'd0);
        check("async_uf", 32'(ERR_UNDERFLOW), 32'd0);
        check("async_ready", ISSUE_READY, 1'b0);
        m_reset();
        #1;
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); step("post_rst");

        // RAW on r5
        fire_rd(5);
        check("raw_busy5", 32'(BUSY_VEC[5]), 32'd1);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); step("raw_stall");
        drive(1, 5, 1, 0, 0, 0, 0, 1, 5, 0); step("raw_wb");
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0, 0); step("raw_after");

        // x0 is never tracked; WAW limit on r7
        fire_rd(0);
        check("x0_inflight", 32'(INFLIGHT), 32'd0);
        fire_rd(7); fire_rd(7); fire_rd(7);
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); step("waw_full");
        wb(7);
        drive(0, 0, 0, 0, 0, 7, 1, 0, 0, 0); step("waw_room");
        check("waw_inflight", 32'(INFLIGHT), 32'd2);
        wb(7); wb(7);

        // Global cap
        fire_rd(1); fire_rd(2); fire_rd(3); fire_rd(4);
        check("cap_inflight", 32'(INFLIGHT), 32'd4);
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); step("cap_block");
        drive(1, 10, 1, 0, 0, 9, 0, 0, 0, 0); step("cap_srconly");
        wb(1); wb(2); wb(3); wb(4);

        // Simultaneous fire and retire on r6
        fire_rd(6);
        drive(1, 0, 0, 0, 0, 6, 1, 1, 6, 0); step("simul");
        check("simul_busy6", 32'(BUSY_VEC[6]), 32'd1);
        check("simul_inflight", 32'(INFLIGHT), 32'd1);
        wb(6);

        // Flush with concurrent fire, then underflow
        fire_rd(1); fire_rd(2); fire_rd(3);
        drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 1); step("flush");
        check("flush_inflight", 32'(INFLIGHT), 32'd0);
        drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 1); step("flush_hold");
        wb(8);
        check("uf_set", 32'(ERR_UNDERFLOW), 32'd1);
        idle(); step("uf_sticky");

        // Short random run over a small register window
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(1), $urandom_range(7), $urandom_range(1),
                  $urandom_range(7), $urandom_range(1), $urandom_range(7),
                  $urandom_range(1), ($urandom_range(2) != 0), $urandom_range(7),
                  ($urandom_range(19) == 0));
            step("rand");
        end

        check("sbq_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register-hazard scoreboard that replaces the fixed EXE/MEM/WB destination-compare stall in the decode stage.
- Keeps a pending-write counter per architectural register; decode presents each candidate instruction and gets ISSUE_READY back.
- Supports a configurable register count, multiple in-flight writers per register (WAW), a global in-flight cap and a pipeline flush for context switches.
- Sits beside decode; writeback reports retired destinations.

Parameters:
- NUM_REGS, 32: architectural registers; index width RW = $clog2(NUM_REGS) (localparam).
- CNT_W, 2: per-register pending counter width; max pending writers per register = 2^CNT_W-1.
- MAX_INFLIGHT, 4: maximum total outstanding register writes across all registers.
- ZERO_REG, 1: 1 means register 0 is hardwired, never tracked and never busy.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- ISSUE_V  in  1  decode holds a valid instruction.
- ISSUE_RS1  in  RW  source 1 index.
- ISSUE_RS2  in  RW  source 2 index.
- ISSUE_USE_RS1  in  1  instruction reads rs1.
- ISSUE_USE_RS2  in  1  instruction reads rs2.
- ISSUE_RD  in  RW  destination index.
- ISSUE_WEN  in  1  instruction writes rd.
- ISSUE_READY  out  1  combinational; instruction may advance this cycle.
- WB_V  in  1  writeback retires a register write this cycle.
- WB_RD  in  RW  retiring destination.
- FLUSH  in  1  kill all in-flight writes (context switch or trap).
- BUSY_VEC  out  NUM_REGS  registered; bit r set when pending[r] != 0.
- INFLIGHT  out  $clog2(MAX_INFLIGHT+1)  registered total of outstanding writes.
- ERR_UNDERFLOW  out  1  sticky; writeback to a register with pending = 0.
- ERR_OVERFLOW  out  1  sticky; FIRE attempted while a limit was reached (protocol violation; never occurs in normal use).

Behaviour:
- Reset (RESET_N = 0, asynchronous): all pending counters, INFLIGHT, BUSY_VEC, ERR_UNDERFLOW and ERR_OVERFLOW go to 0 immediately. ISSUE_READY is 0 while reset is asserted.
- FIRE = ISSUE_V & ISSUE_READY. TRACK_RD = ISSUE_WEN & !(ZERO_REG & ISSUE_RD == 0). Same zero-register rule applies to WB_RD and to the sources.
- ISSUE_READY = !FLUSH & !src1_busy & !src2_busy & (!TRACK_RD | (pending[ISSUE_RD] < 2^CNT_W-1 & INFLIGHT < MAX_INFLIGHT)).
  - src_busy = USE & pending[rs] != 0, evaluated on registered counts.
  - rs1 == rs2 is legal; only one hazard is raised.
  - Out-of-range index (>= NUM_REGS) reads as not busy. If that index is used as a destination, it is not tracked.
- Update at each rising edge:
  - FIRE with TRACK_RD: pending[ISSUE_RD] +1, INFLIGHT +1.
  - WB_V for a tracked register with pending > 0: pending[WB_RD] -1, INFLIGHT -1.
  - WB_V for a tracked register with pending == 0: no change to counters; ERR_UNDERFLOW set.
  - Same register on both FIRE and WB in one cycle: net 0 for pending and INFLIGHT.
- FLUSH: next edge clears all counters and INFLIGHT to 0, overriding FIRE and WB in that cycle. Error flags are not cleared. FLUSH held for N cycles: counters remain 0 and READY remains 0.
- Latency:
  - Issue to busy: 1 cycle, so the next instruction sees the hazard.
  - WB to clear: 1 cycle, unless SB_BYPASS_EN is defined.
- Counters saturate: FIRE never drives them past their limit because READY blocks it.

Optional Feature:
- Macro SB_BYPASS_EN.
- Defined: a source is treated as not busy when pending[rs] == 1 and WB_V & WB_RD == rs in the same cycle. This adds a combinational path WB to ISSUE_READY and saves one stall cycle per dependency.
- Undefined: readiness uses registered counts only, with no WB to READY path.
- Counter update rules are identical in both builds.

Test Plan:
1. Reset: RESET_N low mid-cycle while INFLIGHT = 3 -> all outputs 0 immediately; after release, ISSUE_V = 1, rs1 = 5 -> READY = 1.
2. RAW: fire rd = 5 WEN; next cycle rs1 = 5 USE -> READY = 0, BUSY_VEC[5] = 1. WB_V rd = 5 -> READY = 1 one cycle later without bypass, and in the same cycle with SB_BYPASS_EN.
3. x0 and WAW: fire rd = 0 -> BUSY_VEC = 0, INFLIGHT = 0. Fire rd = 7 three times (CNT_W = 2) -> 4th rd = 7 READY = 0; one WB rd = 7 -> READY = 1, pending = 2.
4. Global cap: fire rd = 1, 2, 3, 4 -> INFLIGHT = 4; rd = 9 READY = 0. A source-only instruction (WEN = 0, rs1 = 10) -> READY = 1.
5. Simultaneous events: pending[6] = 1, fire rd = 6 and WB rd = 6 in the same cycle -> pending[6] = 1, INFLIGHT unchanged.
6. Flush and underflow: INFLIGHT = 3, FLUSH with concurrent FIRE rd = 8 -> next cycle INFLIGHT = 0, BUSY_VEC = 0. Then WB rd = 8 -> ERR_UNDERFLOW = 1 and stays 1.
